// File: rtl/flush_stall_ctrl_reg.sv
// ID/EX control-pipeline register with stall hold, multi-cycle NOP flush,
// valid tracking and a saturating count of inserted flush bubbles.
module flush_stall_ctrl_reg #(
  parameter int CTRL_W       = 13,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush_req,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic              flush_active,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0]       REM_INIT = 4'(FLUSH_CYCLES - 1);
  localparam bit               MULTI    = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [3:0]        rem_q, rem_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              flush_active_q, flush_active_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              insert_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rem_q          <= '0;
      ctrl_q         <= '0;
      valid_q        <= 1'b0;
      flush_active_q <= 1'b0;
      bubble_q       <= '0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      ctrl_q         <= ctrl_d;
      valid_q        <= valid_d;
      flush_active_q <= flush_active_d;
      bubble_q       <= bubble_d;
    end
  end

  // A flush request always reloads the bubble counter, even mid-flush.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (flush_req) begin
      rem_d   = REM_INIT;
      state_d = MULTI ? FLUSH : IDLE;
    end else if (state_q == FLUSH) begin
      rem_d = rem_q - 4'd1;
      if (rem_q == 4'd1) begin
        state_d = IDLE;
      end
    end
  end

  // Stall only matters when no flush is pending or in progress.
  always_comb begin
    ctrl_d        = ctrl_q;
    valid_d       = valid_q;
    insert_bubble = 1'b0;
    if (flush_req || (state_q == FLUSH)) begin
      ctrl_d        = '0;
      valid_d       = 1'b0;
      insert_bubble = 1'b1;
    end else if (!stall) begin
      ctrl_d  = valid_in ? ctrl_in : '0;
      valid_d = valid_in;
    end
    flush_active_d = (state_d == FLUSH);
    bubble_d       = bubble_q;
    if (insert_bubble && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  assign ctrl_out     = ctrl_q;
  assign valid_out    = valid_q;
  assign flush_active = flush_active_q;
  assign bubble_cnt   = bubble_q;

endmodule
